nano_sequencer: RTL and testbench

- Multi-cycle sequencer for the nanoRisc core: fetch, decode, execute, writeback.
- Sits between the instruction ROM / PC and the combinational control unit.
- Gates the control unit's level enables into single-cycle commit strobes, so register bank, accumulator, stack, RAM and PC each update exactly once per instruction.
- Handles two-byte instructions, branches, halt, and RAM wait states with a timeout.

---
 rtl/nano_pkg.sv | 22 ++
 rtl/nano_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_nano_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nano_pkg.sv
// Shared definitions for the nanoRisc instruction sequencer.
package nano_pkg;

  // One state per instruction phase; HALT is terminal until reset.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    FETCH_IMM = 3'd3,
    EXEC      = 3'd4,
    MEM_WAIT  = 3'd5,
    WB        = 3'd6,
    HALT      = 3'd7
  } state_t;

  // Default number of MEM_WAIT cycles tolerated before declaring a fault.
  localparam int MEM_TIMEOUT_DEF = 15;

  // Default width of the retired-instruction counter.
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/nano_sequencer.sv
// Multi-cycle sequencer for the nanoRisc core. Turns the control unit's level
// enables into one-cycle commit strobes so every architectural block updates
// exactly once per instruction. Strobes are registered on entry to the state
// that owns them, so each one is high for exactly the cycles spent in that state.
module nano_sequencer
  import nano_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cu_two_byte,
  input  logic             cu_branch,
  input  logic             cu_halt,
  input  logic             cu_ram_r,
  input  logic             cu_ram_w,
  input  logic             cu_rb_w,
  input  logic             cu_acc_w,
  input  logic             cu_acc_rst,
  input  logic             cu_s_en,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             imm_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             ram_re,
  output logic             ram_we,
  output logic             rb_we,
  output logic             acc_we,
  output logic             acc_clr,
  output logic             stk_step,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  // Wide enough to hold the timeout value itself.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]    r_retired;
  logic                r_fault;
  logic                r_ir_load;
  logic                r_imm_load;
  logic                r_pc_inc;
  logic                r_pc_load;
  logic                r_ram_re;
  logic                r_ram_we;
  logic                r_rb_we;
  logic                r_acc_we;
  logic                r_acc_clr;
  logic                r_stk_step;

  logic                w_mem_op;
  logic [WAIT_W-1:0]   w_wait_next;
  logic                w_timeout;

  // Memory access request and the timeout condition for the current wait cycle.
  // The counter holds completed wait cycles, so w_wait_next numbers the
  // current one; a ready in that same cycle wins over the timeout.
  assign w_mem_op    = cu_ram_r | cu_ram_w;
  assign w_wait_next = r_wait_cnt + WAIT_W'(1);
  assign w_timeout   = (w_wait_next == WAIT_W'(MEM_TIMEOUT));

  // Instruction-phase FSM with registered strobes, wait timer and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_retired  <= '0;
      r_fault    <= 1'b0;
      r_ir_load  <= 1'b0;
      r_imm_load <= 1'b0;
      r_pc_inc   <= 1'b0;
      r_pc_load  <= 1'b0;
      r_ram_re   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_rb_we    <= 1'b0;
      r_acc_we   <= 1'b0;
      r_acc_clr  <= 1'b0;
      r_stk_step <= 1'b0;
    end else begin
      // Every strobe drops unless the state being entered asks for it.
      r_ir_load  <= 1'b0;
      r_imm_load <= 1'b0;
      r_pc_inc   <= 1'b0;
      r_pc_load  <= 1'b0;
      r_ram_re   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_rb_we    <= 1'b0;
      r_acc_we   <= 1'b0;
      r_acc_clr  <= 1'b0;
      r_stk_step <= 1'b0;

      case (r_state)
        IDLE: begin
          if (run) begin
            r_state   <= FETCH;
            r_ir_load <= 1'b1;
            r_pc_inc  <= 1'b1;
          end
        end

        FETCH: begin
          r_state <= DECODE;
        end

        DECODE: begin
          // Halt beats every other decode input.
          if (cu_halt) begin
            r_state <= HALT;
          end else if (cu_two_byte) begin
            r_state    <= FETCH_IMM;
            r_imm_load <= 1'b1;
            r_pc_inc   <= 1'b1;
          end else begin
            r_state  <= EXEC;
            r_ram_re <= cu_ram_r;
            r_ram_we <= cu_ram_w;
          end
        end

        FETCH_IMM: begin
          r_state  <= EXEC;
          r_ram_re <= cu_ram_r;
          r_ram_we <= cu_ram_w;
        end

        EXEC: begin
          if (w_mem_op) begin
            r_state    <= MEM_WAIT;
            r_ram_re   <= cu_ram_r;
            r_ram_we   <= cu_ram_w;
            r_wait_cnt <= '0;
          end else begin
            r_state    <= WB;
            r_rb_we    <= cu_rb_w;
            r_acc_we   <= cu_acc_w;
            r_acc_clr  <= cu_acc_rst;
            r_stk_step <= cu_s_en;
            r_pc_load  <= cu_branch;
          end
        end

        MEM_WAIT: begin
          if (mem_ready) begin
            r_state    <= WB;
            r_rb_we    <= cu_rb_w;
            r_acc_we   <= cu_acc_w;
            r_acc_clr  <= cu_acc_rst;
            r_stk_step <= cu_s_en;
            r_pc_load  <= cu_branch;
          end else if (w_timeout) begin
            // Abandon the instruction: nothing is committed.
            r_state <= HALT;
            r_fault <= 1'b1;
          end else begin
            r_ram_re   <= cu_ram_r;
            r_ram_we   <= cu_ram_w;
            r_wait_cnt <= w_wait_next;
          end
        end

        WB: begin
          r_retired <= r_retired + CNT_W'(1);
          if (run) begin
            r_state   <= FETCH;
            r_ir_load <= 1'b1;
            r_pc_inc  <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end

        HALT: begin
          r_state <= HALT;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ir_load  = r_ir_load;
  assign imm_load = r_imm_load;
  assign pc_inc   = r_pc_inc;
  assign pc_load  = r_pc_load;
  assign ram_re   = r_ram_re;
  assign ram_we   = r_ram_we;
  assign rb_we    = r_rb_we;
  assign acc_we   = r_acc_we;
  assign acc_clr  = r_acc_clr;
  assign stk_step = r_stk_step;
  assign busy     = (r_state != IDLE) && (r_state != HALT);
  assign halted   = (r_state == HALT);
  assign fault    = r_fault;
  assign retired  = r_retired;

endmodule

// File: tb/tb_nano_sequencer.sv
// Self-checking bench for nano_sequencer: directed table, hand-written corner
// sequences and randomized instructions checked against a per-cycle trace
// derived from the instruction-phase rules.
module tb_nano_sequencer;
  import nano_pkg::*;

  localparam int TO = 15;
  localparam int CW = 16;

  typedef logic [12:0] ovec_t;
  localparam ovec_t M_IR    = 13'b1_0000_0000_0000;
  localparam ovec_t M_IMM   = 13'b0_1000_0000_0000;
  localparam ovec_t M_PCI   = 13'b0_0100_0000_0000;
  localparam ovec_t M_PCL   = 13'b0_0010_0000_0000;
  localparam ovec_t M_RE    = 13'b0_0001_0000_0000;
  localparam ovec_t M_WE    = 13'b0_0000_1000_0000;
  localparam ovec_t M_RB    = 13'b0_0000_0100_0000;
  localparam ovec_t M_ACC   = 13'b0_0000_0010_0000;
  localparam ovec_t M_CLR   = 13'b0_0000_0001_0000;
  localparam ovec_t M_STK   = 13'b0_0000_0000_1000;
  localparam ovec_t M_BUSY  = 13'b0_0000_0000_0100;
  localparam ovec_t M_HALT  = 13'b0_0000_0000_0010;
  localparam ovec_t M_FAULT = 13'b0_0000_0000_0001;

  typedef struct {
    logic two, br, hlt, rr, rw, rbw, accw, accr, sen;
    int   ready_at;  // wait cycle in which mem_ready rises; 0 = never
    int   exp_lat;   // busy cycles expected
    bit   exp_halt;
  } vec_t;

  logic clk = 1'b0;
  logic rst, run, mem_ready;
  logic cu_two_byte, cu_branch, cu_halt, cu_ram_r, cu_ram_w;
  logic cu_rb_w, cu_acc_w, cu_acc_rst, cu_s_en;
  logic ir_load, imm_load, pc_inc, pc_load, ram_re, ram_we;
  logic rb_we, acc_we, acc_clr, stk_step, busy, halted, fault;
  logic [CW-1:0] retired;

  int n_chk  = 0;
  int n_fail = 0;
  logic [CW-1:0] model_ret;

  always #5 clk = ~clk;

  nano_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run),
    .cu_two_byte(cu_two_byte), .cu_branch(cu_branch), .cu_halt(cu_halt),
    .cu_ram_r(cu_ram_r), .cu_ram_w(cu_ram_w), .cu_rb_w(cu_rb_w),
    .cu_acc_w(cu_acc_w), .cu_acc_rst(cu_acc_rst), .cu_s_en(cu_s_en),
    .mem_ready(mem_ready),
    .ir_load(ir_load), .imm_load(imm_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .ram_re(ram_re), .ram_we(ram_we), .rb_we(rb_we), .acc_we(acc_we),
    .acc_clr(acc_clr), .stk_step(stk_step), .busy(busy), .halted(halted),
    .fault(fault), .retired(retired)
  );

  function automatic ovec_t dut_out();
    return {ir_load, imm_load, pc_inc, pc_load, ram_re, ram_we, rb_we,
            acc_we, acc_clr, stk_step, busy, halted, fault};
  endfunction

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic vec_t mk(input logic two, br, hlt, rr, rw, rbw, accw, accr, sen,
                              input int ready_at, input int lat, input bit h);
    vec_t v;
    v.two = two; v.br = br; v.hlt = hlt; v.rr = rr; v.rw = rw;
    v.rbw = rbw; v.accw = accw; v.accr = accr; v.sen = sen;
    v.ready_at = ready_at; v.exp_lat = lat; v.exp_halt = h;
    return v;
  endfunction

  // One clock cycle: drive inputs just after the edge, check mid-cycle.
  task automatic step(input string nm, input ovec_t exp, input logic mr, input logic rv);
    ovec_t got;
    mem_ready = mr;
    run       = rv;
    @(negedge clk);
    got = dut_out();
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s outputs: got %b expected %b (t=%0t)", nm, got, exp, $time);
    end
    n_chk++;
    if (retired !== model_ret) begin
      n_fail++;
      $display("FAIL %s retired: got %0d expected %0d (t=%0t)", nm, retired, model_ret, $time);
    end
    n_chk++;
    if (pc_inc && pc_load) begin
      n_fail++;
      $display("FAIL %s pc_inc_pc_load_overlap: got 1 expected 0 (t=%0t)", nm, $time);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = rnd(); mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_ret = '0;
    step("post_reset", '0, 1'b0, 1'b0);
  endtask

  // Expected trace built from the phase rules: F, D, [FI], E, [waits], WB or HALT.
  task automatic do_instr(input vec_t v, input bit from_idle, input bit chain,
                          output int lat, output bit hlt_out);
    ovec_t e;
    ovec_t wb_e;
    logic  mr;
    bit    done;
    lat = 0; hlt_out = 1'b0; done = 1'b0;
    cu_two_byte = v.two; cu_branch = v.br; cu_halt = v.hlt;
    cu_ram_r = v.rr; cu_ram_w = v.rw; cu_rb_w = v.rbw;
    cu_acc_w = v.accw; cu_acc_rst = v.accr; cu_s_en = v.sen;
    if (from_idle) step("idle_launch", '0, 1'b0, 1'b1);
    step("fetch", M_IR | M_PCI | M_BUSY, 1'b0, rnd()); lat++;
    step("decode", M_BUSY, 1'b0, rnd()); lat++;
    if (v.hlt) begin
      for (int i = 0; i < 4; i++) step("halt_hold", M_HALT, 1'b0, logic'(i % 2));
      hlt_out = 1'b1;
    end else begin
      if (v.two) begin
        step("fetch_imm", M_IMM | M_PCI | M_BUSY, 1'b0, rnd()); lat++;
      end
      e = M_BUSY | (v.rr ? M_RE : '0) | (v.rw ? M_WE : '0);
      step("exec", e, 1'b0, rnd()); lat++;
      if (v.rr || v.rw) begin
        for (int k = 1; k <= TO && !done; k++) begin
          mr = (k == v.ready_at);
          step("mem_wait", e, mr, rnd()); lat++;
          if (mr) begin
            done = 1'b1;
          end else if (k == TO) begin
            for (int i = 0; i < 3; i++)
              step("timeout_halt", M_HALT | M_FAULT, 1'b0, logic'(i % 2));
            hlt_out = 1'b1;
            done = 1'b1;
          end
        end
      end
      if (!hlt_out) begin
        wb_e = M_BUSY | (v.br ? M_PCL : '0) | (v.rbw ? M_RB : '0) |
               (v.accw ? M_ACC : '0) | (v.accr ? M_CLR : '0) | (v.sen ? M_STK : '0);
        step("writeback", wb_e, 1'b0, chain); lat++;
        model_ret = model_ret + CW'(1);
      end
    end
    $display("instr two=%0b br=%0b hlt=%0b rr=%0b rw=%0b ready_at=%0d -> lat=%0d halted=%0b retired=%0d",
             v.two, v.br, v.hlt, v.rr, v.rw, v.ready_at, lat, hlt_out, model_ret);
  endtask

  vec_t tbl[9];
  vec_t rv;
  int   lat;
  bit   h;
  bit   from_idle;
  bit   chain;

  initial begin
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0;
    cu_two_byte = 0; cu_branch = 0; cu_halt = 0; cu_ram_r = 0; cu_ram_w = 0;
    cu_rb_w = 0; cu_acc_w = 0; cu_acc_rst = 0; cu_s_en = 0;
    model_ret = '0;

    //            two br hlt rr rw rbw accw accr sen ready lat halt
    tbl[0] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,  0,  4, 0); // ALU op
    tbl[1] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0,  0,  5, 0); // lwi
    tbl[2] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0,  3,  7, 0); // lwm, ready in 3rd wait
    tbl[3] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0,  0, 18, 1); // lwm, never ready
    tbl[4] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0,  0,  5, 0); // bi
    tbl[5] = mk(1, 1, 1, 1, 0, 1, 1, 0, 0,  0,  2, 1); // halt beats the rest
    tbl[6] = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 15, 19, 0); // ready in last wait cycle
    tbl[7] = mk(1, 0, 0, 1, 1, 0, 0, 1, 1,  1,  6, 0); // two-byte, immediate ready
    tbl[8] = mk(0, 1, 0, 0, 0, 1, 1, 1, 1,  0,  4, 0); // all commits together

    do_reset();
    step("idle_hold", '0, 1'b0, 1'b0);
    step("idle_hold", '0, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      do_instr(tbl[i], 1'b1, 1'b0, lat, h);
      n_chk++;
      if (lat !== tbl[i].exp_lat) begin
        n_fail++;
        $display("FAIL table[%0d] latency: got %0d expected %0d", i, lat, tbl[i].exp_lat);
      end
      n_chk++;
      if (h !== tbl[i].exp_halt) begin
        n_fail++;
        $display("FAIL table[%0d] halt_flag: got %0b expected %0b", i, h, tbl[i].exp_halt);
      end
      if (h) do_reset();
      else step("back_to_idle", '0, 1'b0, 1'b0);
    end

    // Back-to-back instructions: run held in WB goes straight to FETCH.
    do_instr(tbl[1], 1'b1, 1'b1, lat, h);
    do_instr(tbl[0], 1'b0, 1'b1, lat, h);
    do_instr(tbl[2], 1'b0, 1'b0, lat, h);
    step("back_to_idle", '0, 1'b0, 1'b0);

    // Reset in the middle of a memory wait aborts without any commit.
    cu_two_byte = 0; cu_branch = 1; cu_halt = 0; cu_ram_r = 1; cu_ram_w = 0;
    cu_rb_w = 1; cu_acc_w = 1; cu_acc_rst = 0; cu_s_en = 1;
    step("idle_launch", '0, 1'b0, 1'b1);
    step("fetch", M_IR | M_PCI | M_BUSY, 1'b0, 1'b1);
    step("decode", M_BUSY, 1'b0, 1'b1);
    step("exec", M_RE | M_BUSY, 1'b0, 1'b1);
    step("mem_wait", M_RE | M_BUSY, 1'b0, 1'b1);
    step("mem_wait", M_RE | M_BUSY, 1'b0, 1'b1);
    rst = 1'b1; run = 1'b1; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_ret = '0;
    step("rst_mid_wait", '0, 1'b0, 1'b0);
    step("rst_mid_wait_hold", '0, 1'b0, 1'b0);
    $display("reset mid MEM_WAIT -> idle, retired=%0d", model_ret);

    // Randomized instruction stream.
    from_idle = 1'b1;
    for (int n = 0; n < 60; n++) begin
      rv = mk(rnd(), rnd(), logic'($urandom_range(0, 7) == 0), rnd(), rnd(),
              rnd(), rnd(), rnd(), rnd(), int'($urandom_range(0, 16)), 0, 0);
      chain = bit'($urandom_range(0, 1));
      if (from_idle && $urandom_range(0, 3) == 0) step("idle_hold", '0, 1'b0, 1'b0);
      do_instr(rv, from_idle, chain, lat, h);
      if (h) begin
        do_reset();
        from_idle = 1'b1;
      end else begin
        from_idle = !chain;
      end
    end
    if (!from_idle) begin
      rv = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4, 0);
      do_instr(rv, 1'b0, 1'b0, lat, h);
    end
    step("final_idle", '0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
